// File: rtl/hwpe_vfpu_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_vfpu_job_ctrl
// Purpose  : VFPU HWPE job controller: config register file, IDLE/RUN/DONE job
//            FSM, element counter, sticky lane flags. Optional cycle counter
//            enabled by macro VFPU_CYCLE_COUNTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_vfpu_job_ctrl #(
  parameter  int N_STREAMS  = 3,
  parameter  int N_LANES    = 4,
  parameter  int CNT_WIDTH  = 16,
  localparam int NB_REGS    = 4*N_STREAMS+6,
  localparam int REG_ADDR_W = $clog2(NB_REGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      reg_req_i,
  input  logic                      reg_wen_i,
  input  logic [REG_ADDR_W-1:0]     reg_addr_i,
  input  logic [31:0]               reg_wdata_i,
  output logic [31:0]               reg_rdata_o,
  output logic                      reg_ack_o,
  output logic [4*N_STREAMS*32-1:0] stream_cfg_o,
  output logic [CNT_WIDTH-1:0]      tsize_o,
  output logic [2:0]                operation_o,
  output logic [1:0]                rounding_o,
  output logic                      start_o,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic                      elem_done_i,
  input  logic                      flags_valid_i,
  input  logic [N_LANES*6-1:0]      lane_flags_i
);

  localparam int NB_STREAM_REGS = 4*N_STREAMS;
  localparam int A_TSIZE  = NB_STREAM_REGS;
  localparam int A_OP     = NB_STREAM_REGS + 1;
  localparam int A_TRIG   = NB_STREAM_REGS + 2;
  localparam int A_STATUS = NB_STREAM_REGS + 3;
  localparam int A_ABORT  = NB_STREAM_REGS + 4;
  localparam int A_CYCLES = NB_STREAM_REGS + 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [31:0]          stream_regs [NB_STREAM_REGS];
  logic [CNT_WIDTH-1:0] tsize;
  logic [CNT_WIDTH-1:0] elem_cnt;
  logic [4:0]           op;
  logic [5:0]           sticky;
  logic [5:0]           lane_or;
  logic                 start_q;
  logic                 ack_q;
  logic [31:0]          rdata_q;
  logic [31:0]          rdata_mux;
  logic [31:0]          cycles_rd;
  logic                 wr, rd, busy;
  logic                 wr_cfg_ok, wr_trig, wr_abort;
  logic                 go, clr, elem_last;

  assign wr        = reg_req_i & reg_wen_i;
  assign rd        = reg_req_i & ~reg_wen_i;
  assign busy      = (state == RUN);
  assign wr_cfg_ok = wr & ~busy;
  assign wr_trig   = wr & (reg_addr_i == REG_ADDR_W'(A_TRIG));
  assign wr_abort  = wr & (reg_addr_i == REG_ADDR_W'(A_ABORT));
  assign elem_last = (elem_cnt == tsize - CNT_WIDTH'(1));
  // Flags and counter are cleared by any accepted trigger, including a zero-size job.
  assign clr       = (state == IDLE) & wr_trig;

  always_comb begin
    state_next = state;
    go         = 1'b0;
    case (state)
      IDLE: begin
        if (wr_trig) begin
          if (tsize != '0) begin
            state_next = RUN;
            go         = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        // An abort wins over a completing element in the same cycle.
        if (wr_abort)                      state_next = IDLE;
        else if (elem_done_i && elem_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= go;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_STREAM_REGS; i++) stream_regs[i] <= '0;
      tsize <= '0;
      op    <= '0;
    end else if (wr_cfg_ok) begin
      for (int i = 0; i < NB_STREAM_REGS; i++)
        if (reg_addr_i == REG_ADDR_W'(i)) stream_regs[i] <= reg_wdata_i;
      if (reg_addr_i == REG_ADDR_W'(A_TSIZE)) tsize <= reg_wdata_i[CNT_WIDTH-1:0];
      if (reg_addr_i == REG_ADDR_W'(A_OP))    op    <= reg_wdata_i[4:0];
    end
  end

  always_comb begin
    lane_or = '0;
    for (int l = 0; l < N_LANES; l++) lane_or = lane_or | lane_flags_i[l*6 +: 6];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_cnt <= '0;
      sticky   <= '0;
    end else if (clr) begin
      elem_cnt <= '0;
      sticky   <= '0;
    end else if (busy) begin
      if (elem_done_i && elem_cnt != '1) elem_cnt <= elem_cnt + CNT_WIDTH'(1);
      if (flags_valid_i)                 sticky   <= sticky | lane_or;
    end
  end

`ifdef VFPU_CYCLE_COUNTER_EN
  logic [31:0] cycles;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   cycles <= '0;
    else if (go)   cycles <= '0;
    else if (busy) cycles <= cycles + 32'd1;
  end

  assign cycles_rd = cycles;
`else
  assign cycles_rd = 32'd0;
`endif

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NB_STREAM_REGS; i++)
      if (reg_addr_i == REG_ADDR_W'(i)) rdata_mux = stream_regs[i];
    if (reg_addr_i == REG_ADDR_W'(A_TSIZE))  rdata_mux = 32'(tsize);
    if (reg_addr_i == REG_ADDR_W'(A_OP))     rdata_mux = {27'd0, op};
    if (reg_addr_i == REG_ADDR_W'(A_STATUS)) rdata_mux = {25'd0, sticky, busy};
    if (reg_addr_i == REG_ADDR_W'(A_CYCLES)) rdata_mux = cycles_rd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= reg_req_i;
      rdata_q <= rd ? rdata_mux : 32'd0;
    end
  end

  for (genvar g = 0; g < NB_STREAM_REGS; g++) begin : g_stream_flat
    assign stream_cfg_o[g*32 +: 32] = stream_regs[g];
  end

  assign reg_ack_o   = ack_q;
  assign reg_rdata_o = rdata_q;
  assign tsize_o     = tsize;
  assign operation_o = op[2:0];
  assign rounding_o  = op[4:3];
  assign start_o     = start_q;
  assign busy_o      = busy;
  assign done_o      = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_hwpe_vfpu_job_ctrl.sv
`default_nettype none
// Testbench for hwpe_vfpu_job_ctrl: register vector table plus job sequences,
// read data checked through a scoreboard queue drained on reg_ack_o.
module tb_hwpe_vfpu_job_ctrl;

  localparam int N_STREAMS = 3;
  localparam int N_LANES   = 4;
  localparam int CNT_WIDTH = 16;
  localparam int AW        = 5;
  localparam int A_TSIZE = 12, A_OP = 13, A_TRIG = 14, A_STAT = 15, A_ABORT = 16, A_CYC = 17;
`ifdef VFPU_CYCLE_COUNTER_EN
  localparam logic [31:0] EXP_CYC = 32'd7;
`else
  localparam logic [31:0] EXP_CYC = 32'd0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      req = 1'b0, wen = 1'b0;
  logic [AW-1:0]             addr = '0;
  logic [31:0]               wdata = '0;
  logic [31:0]               rdata;
  logic                      ack;
  logic [4*N_STREAMS*32-1:0] stream_cfg;
  logic [CNT_WIDTH-1:0]      tsize;
  logic [2:0]                operation;
  logic [1:0]                rounding;
  logic                      start_o, busy_o, done_o;
  logic                      elem_done = 1'b0, flags_valid = 1'b0;
  logic [N_LANES*6-1:0]      lane_flags = '0;

  always #5 clk = ~clk;

  hwpe_vfpu_job_ctrl #(.N_STREAMS(N_STREAMS), .N_LANES(N_LANES), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_wen_i(wen), .reg_addr_i(addr),
    .reg_wdata_i(wdata), .reg_rdata_o(rdata), .reg_ack_o(ack), .stream_cfg_o(stream_cfg),
    .tsize_o(tsize), .operation_o(operation), .rounding_o(rounding), .start_o(start_o),
    .busy_o(busy_o), .done_o(done_o), .elem_done_i(elem_done), .flags_valid_i(flags_valid),
    .lane_flags_i(lane_flags)
  );

  int checks = 0, failures = 0;
  int start_cnt = 0, done_cnt = 0;

  typedef struct { logic is_rd; int addr; logic [31:0] exp; } sb_t;
  typedef struct { logic wen; int addr; logic [31:0] wdata; logic [31:0] exp; } vec_t;
  sb_t  sb[$];
  logic req_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input int a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wen = w; v.addr = a; v.wdata = d; v.exp = e;
    return v;
  endfunction

  // Expected acknowledge: one cycle after every sampled request.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) req_q <= 1'b0;
    else        req_q <= req;

  always @(negedge clk) begin
    sb_t e;
    if (start_o) start_cnt++;
    if (done_o)  done_cnt++;
    if (rst_n) begin
      chk("ack_timing", 32'(ack), 32'(req_q));
      if (ack) begin
        if (sb.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          if (e.is_rd) chk($sformatf("rdata_addr%0d", e.addr), rdata, e.exp);
        end
      end else begin
        chk("rdata_idle", rdata, 32'd0);
      end
    end
  end

  task automatic reg_op(input logic w, input int a, input logic [31:0] d, input logic [31:0] e);
    sb_t s;
    @(negedge clk);
    req = 1'b1; wen = w; addr = AW'(a); wdata = d;
    s.is_rd = ~w; s.addr = a; s.exp = e;
    sb.push_back(s);
    @(negedge clk);
    req = 1'b0; wen = 1'b0;
  endtask

  task automatic elem_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      elem_done = 1'b1;
      @(negedge clk);
    end
    elem_done = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"},   32'(ack), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_cfg"},   32'(stream_cfg != '0), 32'd0);
    chk({tag, "_tsize"}, 32'(tsize), 32'd0);
    chk({tag, "_op"},    32'({rounding, operation}), 32'd0);
    chk({tag, "_ctl"},   32'({start_o, busy_o, done_o}), 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    int   s0, d0;

    vecs.push_back(mk(1'b1, 4,       32'hA5A5_0000, 32'h0));
    vecs.push_back(mk(1'b0, 4,       32'h0,         32'hA5A5_0000));
    vecs.push_back(mk(1'b1, 0,       32'h1111_1111, 32'h0));
    vecs.push_back(mk(1'b1, 11,      32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(1'b0, 0,       32'h0,         32'h1111_1111));
    vecs.push_back(mk(1'b0, 11,      32'h0,         32'hDEAD_BEEF));
    vecs.push_back(mk(1'b1, 20,      32'h1234_5678, 32'h0));
    vecs.push_back(mk(1'b0, 20,      32'h0,         32'h0));
    vecs.push_back(mk(1'b0, 31,      32'h0,         32'h0));
    vecs.push_back(mk(1'b1, A_ABORT, 32'h1,         32'h0));
    vecs.push_back(mk(1'b0, A_ABORT, 32'h0,         32'h0));
    vecs.push_back(mk(1'b0, A_TRIG,  32'h0,         32'h0));
    vecs.push_back(mk(1'b0, A_STAT,  32'h0,         32'h0));
    vecs.push_back(mk(1'b1, A_TSIZE, 32'h5,         32'h0));
    vecs.push_back(mk(1'b0, A_TSIZE, 32'h0,         32'h5));
    vecs.push_back(mk(1'b1, A_OP,    32'h0B,        32'h0));
    vecs.push_back(mk(1'b0, A_OP,    32'h0,         32'h0B));
    vecs.push_back(mk(1'b0, A_CYC,   32'h0,         32'h0));

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) reg_op(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    chk("cfg_reg4",  stream_cfg[159:128], 32'hA5A5_0000);
    chk("cfg_reg0",  stream_cfg[31:0],    32'h1111_1111);
    chk("cfg_reg11", stream_cfg[383:352], 32'hDEAD_BEEF);
    chk("operation", 32'(operation), 32'd3);
    chk("rounding",  32'(rounding),  32'd1);
    chk("tsize_out", 32'(tsize),     32'd5);

    // Five-element job
    s0 = start_cnt; d0 = done_cnt;
    reg_op(1'b1, A_TRIG, 32'h1, 32'h0);
    chk("job5_start", 32'(start_o), 32'd1);
    chk("job5_busy",  32'(busy_o),  32'd1);
    elem_pulses(4);
    chk("job5_start_dropped", 32'(start_o), 32'd0);
    chk("job5_busy_mid",      32'({busy_o, done_o}), 32'b10);
    elem_pulses(1);
    chk("job5_done",  32'({busy_o, done_o}), 32'b01);
    @(negedge clk);
    chk("job5_after", 32'({busy_o, done_o}), 32'b00);
    @(negedge clk);
    chk("job5_start_count", 32'(start_cnt - s0), 32'd1);
    chk("job5_done_count",  32'(done_cnt - d0),  32'd1);

    // Zero-size job completes without a start pulse
    s0 = start_cnt; d0 = done_cnt;
    reg_op(1'b1, A_TSIZE, 32'h0, 32'h0);
    reg_op(1'b1, A_TRIG,  32'h1, 32'h0);
    chk("tsz0_done", 32'({start_o, busy_o, done_o}), 32'b001);
    @(negedge clk);
    chk("tsz0_after", 32'(done_o), 32'd0);
    @(negedge clk);
    chk("tsz0_start_count", 32'(start_cnt - s0), 32'd0);
    chk("tsz0_done_count",  32'(done_cnt - d0),  32'd1);

    // Sticky flags, busy write protection, abort
    reg_op(1'b1, A_TSIZE, 32'h8, 32'h0);
    reg_op(1'b1, A_TRIG,  32'h1, 32'h0);
    lane_flags = '1; flags_valid = 1'b0;
    @(negedge clk);
    lane_flags = 24'h01_0000; flags_valid = 1'b1;
    @(negedge clk);
    lane_flags = 24'h00_0004;
    @(negedge clk);
    lane_flags = '0; flags_valid = 1'b0;
    reg_op(1'b0, A_STAT, 32'h0, 32'h29);
    elem_pulses(3);
    reg_op(1'b1, A_TSIZE, 32'h10, 32'h0);
    reg_op(1'b0, A_TSIZE, 32'h0,  32'h8);
    reg_op(1'b1, 4,       32'hFFFF_FFFF, 32'h0);
    reg_op(1'b0, 4,       32'h0,  32'hA5A5_0000);
    reg_op(1'b1, A_OP,    32'h7,  32'h0);
    reg_op(1'b0, A_OP,    32'h0,  32'h0B);
    reg_op(1'b1, A_TRIG,  32'h1,  32'h0);
    chk("retrigger_ignored", 32'({start_o, busy_o}), 32'b01);
    d0 = done_cnt;
    reg_op(1'b1, A_ABORT, 32'h1, 32'h0);
    chk("abort_idle", 32'({busy_o, done_o}), 32'b00);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    reg_op(1'b0, A_STAT, 32'h0, 32'h28);
    flags_valid = 1'b1; lane_flags = '1; elem_done = 1'b1;
    @(negedge clk);
    flags_valid = 1'b0; lane_flags = '0; elem_done = 1'b0;
    chk("idle_inputs_ignored", 32'({busy_o, done_o}), 32'b00);
    reg_op(1'b0, A_STAT, 32'h0, 32'h28);

    // Seven-cycle job for the cycle counter
    reg_op(1'b1, A_TSIZE, 32'h7, 32'h0);
    reg_op(1'b1, A_TRIG,  32'h1, 32'h0);
    elem_pulses(7);
    chk("job7_done", 32'(done_o), 32'd1);
    reg_op(1'b0, A_CYC, 32'h0, EXP_CYC);
    reg_op(1'b0, A_STAT, 32'h0, 32'h0);

    // Asynchronous reset in the middle of a job
    reg_op(1'b1, A_TSIZE, 32'h8, 32'h0);
    reg_op(1'b1, A_TRIG,  32'h1, 32'h0);
    elem_pulses(2);
    chk("pre_reset_busy", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("midjob_reset");
    @(negedge clk);
    rst_n = 1'b1;
    reg_op(1'b0, A_TSIZE, 32'h0, 32'h0);
    reg_op(1'b0, 4,       32'h0, 32'h0);
    reg_op(1'b0, A_STAT,  32'h0, 32'h0);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
